// File: rtl/load_store_unit.sv
// load_store_unit: byte-serial load/store engine for a RISC-V style core.
// A request is latched in IDLE, checked for legality, then moved one byte per
// cycle over an 8-bit memory port in big-endian order. Loads are assembled in
// an accumulator and extended on completion; every request ends with a single
// DONE cycle that carries the done pulse and the err flag.
module load_store_unit (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic        we,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [31:0] rdata,
  output logic        mem_read,
  output logic        mem_write,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  // The data memory is 128 bytes, so only address bits [6:0] may be set.
  localparam int ADDR_BITS = 7;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic        we_q, we_d;
  logic [2:0]  funct3_q, funct3_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  // Index of the final byte of the access (N-1), and the current byte index k.
  logic [1:0]  last_q, last_d;
  logic [1:0]  k_q, k_d;
  logic [31:0] acc_q, acc_d;
  logic [31:0] rdata_q, rdata_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        err_q, err_d;
  logic        mem_read_q, mem_read_d;
  logic        mem_write_q, mem_write_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic [31:0] mem_wdata_q, mem_wdata_d;

  // Request decode results for the incoming (not yet latched) request.
  logic [1:0]  req_last;
  logic        req_legal;
  logic [1:0]  k_next;
  logic [31:0] acc_shift;

  // Only the low byte of the memory read bus carries data.
  logic        unused_rdata_hi;
  assign unused_rdata_hi = ^mem_rdata[31:8];

  assign k_next    = k_q + 2'd1;
  assign acc_shift = {acc_q[23:0], mem_rdata[7:0]};

  // Pick byte lane 'lane' (0 = least significant) of a store word.
  function automatic logic [7:0] store_byte(input logic [31:0] data, input logic [1:0] lane);
    logic [31:0] shifted;
    shifted = data >> {lane, 3'b000};
    return shifted[7:0];
  endfunction

  // Turn the raw big-endian accumulator into the architectural load result.
  function automatic logic [31:0] extend_load(input logic [2:0] f3, input logic [31:0] raw);
    logic [31:0] result;
    case (f3)
      3'b000:  result = {{24{raw[7]}}, raw[7:0]};
      3'b001:  result = {{16{raw[15]}}, raw[15:0]};
      3'b100:  result = {24'h000000, raw[7:0]};
      3'b101:  result = {16'h0000, raw[15:0]};
      default: result = raw;
    endcase
    return result;
  endfunction

  // Decode access size and legality of the request presented on the inputs.
  always_comb begin
    req_last  = 2'd0;
    req_legal = 1'b1;
    case (funct3)
      3'b000: req_last = 2'd0;
      3'b001: begin
        req_last = 2'd1;
        if (addr[0]) req_legal = 1'b0;
      end
      3'b010: begin
        req_last = 2'd3;
        if (addr[1:0] != 2'b00) req_legal = 1'b0;
      end
      3'b100: begin
        req_last = 2'd0;
        if (we) req_legal = 1'b0;
      end
      3'b101: begin
        req_last = 2'd1;
        if (we || addr[0]) req_legal = 1'b0;
      end
      default: req_legal = 1'b0;
    endcase
    if (addr[31:ADDR_BITS] != '0) req_legal = 1'b0;
  end

  // Next-state and next-output logic; every output is driven from a flop.
  always_comb begin
    state_d     = state_q;
    we_d        = we_q;
    funct3_d    = funct3_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    last_d      = last_q;
    k_d         = k_q;
    acc_d       = acc_q;
    rdata_d     = rdata_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    err_d       = 1'b0;
    mem_read_d  = 1'b0;
    mem_write_d = 1'b0;
    mem_addr_d  = 32'h0;
    mem_wdata_d = 32'h0;

    case (state_q)
      IDLE: begin
        if (req) begin
          we_d     = we;
          funct3_d = funct3;
          addr_d   = addr;
          wdata_d  = wdata;
          last_d   = req_last;
          k_d      = 2'd0;
          acc_d    = 32'h0;
          busy_d   = 1'b1;
          if (req_legal) begin
            // Byte 0 is the most significant byte of the access.
            state_d     = ACCESS;
            mem_read_d  = ~we;
            mem_write_d = we;
            mem_addr_d  = addr;
            mem_wdata_d = we ? {24'h000000, store_byte(wdata, req_last)} : 32'h0;
          end else begin
            // Rejected: straight to DONE with no memory traffic.
            state_d = DONE;
            done_d  = 1'b1;
            err_d   = 1'b1;
          end
        end
      end

      ACCESS: begin
        if (!we_q) acc_d = acc_shift;
        if (k_q == last_q) begin
          state_d = DONE;
          done_d  = 1'b1;
          if (!we_q) rdata_d = extend_load(funct3_q, acc_shift);
        end else begin
          k_d         = k_next;
          mem_read_d  = ~we_q;
          mem_write_d = we_q;
          mem_addr_d  = addr_q + {30'h0, k_next};
          mem_wdata_d = we_q ? {24'h000000, store_byte(wdata_q, last_q - k_next)} : 32'h0;
        end
      end

      DONE: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end

      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and output registers; reset overrides any request or access in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      we_q        <= 1'b0;
      funct3_q    <= 3'b000;
      addr_q      <= 32'h0;
      wdata_q     <= 32'h0;
      last_q      <= 2'd0;
      k_q         <= 2'd0;
      acc_q       <= 32'h0;
      rdata_q     <= 32'h0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
      mem_addr_q  <= 32'h0;
      mem_wdata_q <= 32'h0;
    end else begin
      state_q     <= state_d;
      we_q        <= we_d;
      funct3_q    <= funct3_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      last_q      <= last_d;
      k_q         <= k_d;
      acc_q       <= acc_d;
      rdata_q     <= rdata_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      err_q       <= err_d;
      mem_read_q  <= mem_read_d;
      mem_write_q <= mem_write_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign err       = err_q;
  assign rdata     = rdata_q;
  assign mem_read  = mem_read_q;
  assign mem_write = mem_write_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 SHALL have these ports, one per line: name  direction  width  meaning.
- clk  in  1  single clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- req  in  1  access request from the core; sampled only in IDLE.
- we  in  1  1 = store, 0 = load; sampled with req.
- funct3  in  3  RISC-V width code: 000 LB/SB, 001 LH/SH, 010 LW/SW, 100 LBU, 101 LHU; sampled with req.
- addr  in  32  byte address; sampled with req.
- wdata  in  32  store data; sampled with req.
- busy  out  1  high from the cycle after acceptance through the done cycle.
- done  out  1  one-cycle completion pulse.
- err  out  1  valid with done; 1 = request rejected.
- rdata  out  32  extended load result; holds until the next successful load completes.
- mem_read  out  1  byte read strobe to data memory.
- mem_write  out  1  byte write strobe to data memory.
- mem_addr  out  32  byte address to data memory.
- mem_wdata  out  32  store byte in [7:0]; [31:8] are zero.
- mem_rdata  in  32  combinational byte read from memory; only [7:0] is used.
REQ-002 SHALL have no parameters; the memory size is fixed at 128 bytes.

Function
REQ-003 SHALL implement FSM states IDLE, ACCESS and DONE.
REQ-004 SHALL, in IDLE with req=1, latch we, funct3, addr and wdata, and set the byte count N: 1 for funct3 000/100, 2 for 001/101, 4 for 010.
REQ-005 SHALL reject a request and go IDLE->DONE with err=1 and no memory strobes, when any of the following holds:
- funct3 is unsupported (011, 110, 111, or 100/101 with we=1);
- the halfword is misaligned (addr[0]=1);
- the word is misaligned (addr[1:0]!=0);
- addr[31:7]!=0.
REQ-006 SHALL otherwise go IDLE->ACCESS and spend exactly N cycles in ACCESS, with byte index k=0..N-1.
REQ-007 SHALL drive mem_addr=addr+k in each ACCESS cycle, with mem_read=~we and mem_write=we.
REQ-008 SHALL use big-endian byte order: byte addr+0 is the most significant byte of the access.
REQ-009 SHALL, on a store, drive mem_wdata[7:0]=wdata[8*(N-1-k)+7 : 8*(N-1-k)].
REQ-010 SHALL, on a load, capture mem_rdata[7:0] at the end of each ACCESS cycle into an accumulator (shift left 8, OR byte).
REQ-011 SHALL go ACCESS->DONE after byte N-1, then DONE->IDLE unconditionally.
REQ-012 SHALL assert done (with err) for exactly the DONE cycle; done rises N+1 cycles after the accepting edge, or 1 cycle after for rejects.
REQ-013 SHALL update rdata on entry to DONE for successful loads only:
- LB/LH sign-extend from bit 7/15;
- LBU/LHU zero-extend;
- LW is passed through unchanged.
REQ-014 SHALL leave rdata unchanged on stores and on rejected requests.
REQ-015 SHALL hold mem_read, mem_write, mem_addr and mem_wdata at 0 outside ACCESS.
REQ-016 SHALL ignore req while busy; a request held high during DONE is accepted on the first IDLE cycle after.
REQ-017 SHALL never issue mem_read and mem_write in the same cycle.

Reset
REQ-018 SHALL, when reset=1 at a clock edge, force IDLE and set these to 0: busy, done, err, rdata, accumulator, mem_read, mem_write, mem_addr and mem_wdata.
REQ-019 SHALL let reset take priority over req and over any ACCESS progress.
REQ-020 SHALL issue no further strobes after a mid-operation reset; bytes already written stay written, and no done is generated for the aborted access.

Verification
REQ-021 SHALL pass: memory bytes 4..7 = 00 00 00 0A, LW addr=4 -> four reads at addresses 4,5,6,7, done 5 cycles after accept, rdata=0x0000000A, err=0.
REQ-022 SHALL pass: SW addr=8 wdata=0x80817F01 -> writes 80,81,7F,01 to addresses 8..11; then LB 8 -> 0xFFFFFF80, LBU 8 -> 0x00000080, LH 8 -> 0xFFFF8081, LHU 10 -> 0x00007F01.
REQ-023 SHALL pass: LW addr=6 and LH addr=9 -> done 1 cycle after accept, err=1, no strobes, rdata unchanged.
REQ-024 SHALL pass: LB addr=0x80 and SB with funct3=100 -> err=1, no strobes.
REQ-025 SHALL pass: SW addr=12 wdata=0xAABBCCDD with reset asserted after 2 ACCESS cycles -> bytes 12,13 = AA,BB; bytes 14,15 unchanged; busy=0 and done=0 the cycle after reset.
REQ-026 SHALL pass: req held high continuously across two back-to-back SB requests -> the second is accepted only after DONE, with exactly one write strobe per request.
